// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider for the multdiv unit.
// Works on operand magnitudes, one trial subtraction per clock, then applies
// result signs in a single fix-up cycle. Divide-by-zero completes immediately.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] mag_b_reg;
    logic             sign_q_reg;
    logic             sign_r_reg;

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;

    // Operand magnitudes: negate only negative operands of a signed divide.
    // The most negative value negates to itself, which is its correct
    // unsigned magnitude.
    always_comb begin
        neg_a = signed_op & dividend[WIDTH-1];
        neg_b = signed_op & divisor[WIDTH-1];
        mag_a = neg_a ? (~dividend + 1'b1) : dividend;
        mag_b = neg_b ? (~divisor + 1'b1) : divisor;
    end

    // One restoring step: shift the next quotient bit into R and trial-subtract
    // the divisor magnitude on WIDTH+1 bits; the top bit is the borrow.
    always_comb begin
        shifted  = {rem_reg, quo_reg[WIDTH-1]};
        trial    = shifted - {1'b0, mag_b_reg};
        trial_ok = ~trial[WIDTH];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            mag_b_reg  <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        count_reg <= '0;
                        if (divisor == '0) begin
                            // No iterations needed; report straight away.
                            quotient  <= '0;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                            done      <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            rem_reg    <= '0;
                            quo_reg    <= mag_a;
                            mag_b_reg  <= mag_b;
                            sign_q_reg <= neg_a ^ neg_b;
                            sign_r_reg <= neg_a;
                            state_reg  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Q doubles as the dividend shift register: its MSB feeds R
                    // and the new quotient bit enters at the LSB.
                    rem_reg   <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo_reg   <= {quo_reg[WIDTH-2:0], trial_ok};
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_STEP) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Truncation toward zero: remainder takes the dividend sign.
                    quotient  <= sign_q_reg ? (~quo_reg + 1'b1) : quo_reg;
                    remainder <= sign_r_reg ? (~rem_reg + 1'b1) : rem_reg;
                    div_zero  <= 1'b0;
                    done      <= 1'b1;
                    state_reg <= S_DONE;
                end
                default: begin
                    // S_DONE: one-cycle pulse; start here is deliberately dropped.
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed tests for seq_divider with a cycle-level reference
// model (plain integer division on magnitudes) compared every clock.
module tb_seq_divider;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_zero;

    logic         start8 = 1'b0;
    logic         signed8 = 1'b0;
    logic [7:0]   dvd8 = '0;
    logic [7:0]   dvs8 = '0;
    logic [7:0]   q8;
    logic [7:0]   r8;
    logic         busy8;
    logic         done8;
    logic         dz8;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seq_divider #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .busy(busy), .done(done), .div_zero(div_zero)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .signed_op(signed8),
        .dividend(dvd8), .divisor(dvs8), .quotient(q8),
        .remainder(r8), .busy(busy8), .done(done8), .div_zero(dz8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } res_t;

    function automatic res_t model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   res;
        logic   sa, sb;
        longint ma, mb, q64, r64;
        logic [W-1:0] qm, rm;
        if (b == 0) begin
            res.q  = '0;
            res.r  = a;
            res.dz = 1'b1;
        end else begin
            sa  = sg & a[W-1];
            sb  = sg & b[W-1];
            ma  = sa ? (64'h1_0000_0000 - longint'(a)) : longint'(a);
            mb  = sb ? (64'h1_0000_0000 - longint'(b)) : longint'(b);
            q64 = ma / mb;
            r64 = ma % mb;
            qm  = q64[W-1:0];
            rm  = r64[W-1:0];
            res.q  = (sa ^ sb) ? -qm : qm;
            res.r  = sa ? -rm : rm;
            res.dz = 1'b0;
        end
        return res;
    endfunction

    // m_left: cycles remaining in the current operation (0 = idle);
    // done is expected in the cycle where m_left == 1.
    res_t m_res;
    res_t p_res;
    int   m_left;

    // Model timing: accepts start when idle; results visible with done.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_left <= 0;
            m_res  <= '0;
            p_res  <= '0;
        end else if (m_left == 0) begin
            if (start) begin
                if (divisor == 0) begin
                    m_res  <= model(signed_op, dividend, divisor);
                    m_left <= 1;
                end else begin
                    p_res  <= model(signed_op, dividend, divisor);
                    m_left <= W + 2;
                end
            end
        end else begin
            if (m_left == 2) m_res <= p_res;
            m_left <= m_left - 1;
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        check("busy", 64'(busy), 64'(m_left != 0));
        check("done", 64'(done), 64'(m_left == 1));
        check("quotient", 64'(quotient), 64'(m_res.q));
        check("remainder", 64'(remainder), 64'(m_res.r));
        check("div_zero", 64'(div_zero), 64'(m_res.dz));
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(output int n);
        bit seen;
        n = 0;
        seen = 0;
        while (n < 200 && !seen) begin
            @(negedge clock);
            n++;
            if (done) seen = 1;
        end
        if (!seen) check("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_op(input string name, input logic sg, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic edz, input int elat);
        int n;
        @(posedge clock); #1;
        start = 1'b1; signed_op = sg; dividend = a; divisor = b;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(n);
        check({name, "_latency"}, 64'(n), 64'(elat));
        check({name, "_q"}, 64'(quotient), 64'(eq));
        check({name, "_r"}, 64'(remainder), 64'(er));
        check({name, "_dz"}, 64'(div_zero), 64'(edz));
        $display("op %s: sg=%0d a=0x%0h b=0x%0h -> q=0x%0h r=0x%0h dz=%0d lat=%0d",
                 name, sg, a, b, quotient, remainder, div_zero, n);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_q", 64'(quotient), 64'(0));
        @(posedge clock); #2;
        reset_n = 1'b1;

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        run_op("sm100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34);
        run_op("s100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 34);
        run_op("sm100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, 34);
        run_op("divzero", 1'b0, 32'h1234, 32'd0, 32'd0, 32'h1234, 1'b1, 1);
        run_op("clear_dz", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34);
        run_op("u_big", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 34);
        run_op("u_max_2", 1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 1'b0, 34);

        // Start pulsed mid-run with new operands must be ignored.
        @(posedge clock); #1;
        start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        start = 1'b1; dividend = 32'd200; divisor = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(n);
        check("ignore_q", 64'(quotient), 64'(14));
        check("ignore_r", 64'(remainder), 64'(2));
        $display("op ignore_mid_start: q=0x%0h r=0x%0h", quotient, remainder);

        // Start held high: second op accepted in the first idle cycle after done.
        @(posedge clock); #1;
        start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
        @(posedge clock); #1;
        wait_done(n);
        check("held1_latency", 64'(n), 64'(34));
        check("held1_q", 64'(quotient), 64'(100));
        @(posedge clock);
        @(negedge clock);
        check("held_gap_busy", 64'(busy), 64'(0));
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(n);
        check("held2_latency", 64'(n), 64'(34));
        check("held2_q", 64'(quotient), 64'(100));
        $display("op held_start: q=0x%0h r=0x%0h lat=%0d", quotient, remainder, n);

        // Asynchronous reset in the middle of a run.
        @(posedge clock); #1;
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_busy", 64'(busy), 64'(0));
        check("areset_q", 64'(quotient), 64'(0));
        check("areset_r", 64'(remainder), 64'(0));
        $display("op async_reset: busy=%0d q=0x%0h r=0x%0h", busy, quotient, remainder);
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        run_op("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34);

        // Narrow instance: 8-bit unsigned 255/16.
        @(posedge clock); #1;
        start8 = 1'b1; dvd8 = 8'd255; dvs8 = 8'd16;
        @(posedge clock); #1;
        start8 = 1'b0;
        begin
            bit seen;
            n = 0;
            seen = 0;
            while (n < 100 && !seen) begin
                @(negedge clock);
                n++;
                if (done8) seen = 1;
            end
            if (!seen) check("w8_timeout", 64'(0), 64'(1));
        end
        check("w8_latency", 64'(n), 64'(10));
        check("w8_q", 64'(q8), 64'(15));
        check("w8_r", 64'(r8), 64'(15));
        $display("op w8_255_16: q=0x%0h r=0x%0h lat=%0d", q8, r8, n);

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
